// File: rtl/indirect_access_cntrl_pkg.sv
// Shared types and constants for the indirect-access controller.
// Holds the command opcodes, the status codes reported through stat_code,
// the FSM state encoding and the fixed capability/geometry constants of the
// single memory instance this controller fronts.
package indirect_access_cntrl_pkg;

  localparam int                   N_REG_ADDR_BITS = 11;
  localparam int                   ADDR_W          = 9;   // 512 entries
  localparam int                   N_DATA_BITS     = 96;
  localparam int                   N_TIMER_BITS    = 6;
  localparam int                   N_TABLES        = 1;
  localparam int                   ALIGNMENT       = 2;
  localparam int                   N_ENTRIES       = 512;
  localparam logic [10:0]          CMND_ADDRESS    = 11'h080;
  localparam logic [10:0]          STAT_ADDRESS    = 11'h070;
  localparam logic [3:0]           MEM_TYPE        = 4'd0;
  localparam logic [15:0]          CAPABILITIES    = 16'hC17F;
  localparam logic [4:0]           N_DATAWORDS     = 5'd2;

  typedef enum logic [3:0] {
    OP_NOP            = 4'd0,
    OP_READ           = 4'd1,
    OP_WRITE          = 4'd2,
    OP_ENABLE         = 4'd3,
    OP_DISABLE        = 4'd4,
    OP_RESET          = 4'd5,
    OP_INIT           = 4'd6,
    OP_INIT_INC       = 4'd7,
    OP_SET_INIT_START = 4'd8,
    OP_COMPARE        = 4'd9,
    OP_SIM_TMO        = 4'd14,
    OP_ACK_ERROR      = 4'd15
  } ia_operation_e;

  typedef enum logic [2:0] {
    ST_RDY = 3'd0,
    ST_BSY = 3'd1,
    ST_TMO = 3'd2,
    ST_OVR = 3'd3,
    ST_NXM = 3'd4,
    ST_UOP = 3'd5,
    ST_PDN = 3'd7
  } ia_status_e;

  typedef enum logic [3:0] {
    S_POWERDOWN,
    S_READY,
    S_DO_WRITE,
    S_DO_READ,
    S_READ_DONE,
    S_DO_COMPARE,
    S_COMPARE_WAIT,
    S_COMPARE_DONE,
    S_DO_RESET,
    S_DO_INIT,
    S_ERROR
  } state_e;

endpackage

// File: rtl/indirect_access_cntrl_if.sv
// Single-port memory interface between the indirect-access controller
// (master) and the memory instance / arbiter (slave).
//   sw_cs/sw_ce/sw_we : chip select, compare enable, write enable
//   sw_add, sw_wdat   : access address and write data
//   sw_rdat           : read data, sw_match/sw_aindex : compare result
//   grant             : arbiter grant, yield : controller asks to yield
//   reset             : a reset/init sweep is in progress
interface indirect_access_cntrl_if;
  import indirect_access_cntrl_pkg::*;

  logic                   sw_cs;
  logic                   sw_ce;
  logic                   sw_we;
  logic [ADDR_W-1:0]      sw_add;
  logic [N_DATA_BITS-1:0] sw_wdat;
  logic [N_DATA_BITS-1:0] sw_rdat;
  logic                   sw_match;
  logic [7:0]             sw_aindex;
  logic                   grant;
  logic                   yield;
  logic                   reset;

  modport master (
    output sw_cs, sw_ce, sw_we, sw_add, sw_wdat, yield, reset,
    input  sw_rdat, sw_match, sw_aindex, grant
  );

  modport slave (
    input  sw_cs, sw_ce, sw_we, sw_add, sw_wdat, yield, reset,
    output sw_rdat, sw_match, sw_aindex, grant
  );

endinterface

// File: rtl/indirect_access_cntrl.sv
// Indirect-access controller: decodes command writes to the CSR command
// register and runs read/write/compare/reset/init sequences on one
// single-port memory, reporting progress and errors through stat_code.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   wr_stb, reg_addr           CSR write strobe and address
//   cmnd_op/addr/table_id      command fields
//   stat_*, capability_*       status and capability outputs
//   enable                     table usable (not in powerdown init)
//   addr_limit                 per-table maximum address
//   wr_dat, rd_dat             CSR data in, registered data out
//   mem                        memory interface (master side)
//
// state          | meaning
// POWERDOWN      | table disabled, rd_dat follows wr_dat
// READY          | idle, accepting commands
// DO_WRITE       | write pending, waiting for grant
// DO_READ        | read pending, waiting for grant
// READ_DONE      | capture read data
// DO_COMPARE     | compare pending, waiting for grant
// COMPARE_WAIT   | memory compare pipeline stage
// COMPARE_DONE   | capture match/index
// DO_RESET       | clearing entries 0..maxaddr
// DO_INIT        | writing wr_dat from rst_addr up to cmnd_addr
// ERROR          | error latched until ACK_ERROR
module indirect_access_cntrl
  import indirect_access_cntrl_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_stb,
  input  logic [N_REG_ADDR_BITS-1:0]          reg_addr,
  input  logic [3:0]                          cmnd_op,
  input  logic [ADDR_W-1:0]                   cmnd_addr,
  input  logic                                cmnd_table_id,
  output logic [2:0]                          stat_code,
  output logic [4:0]                          stat_datawords,
  output logic [ADDR_W-1:0]                   stat_addr,
  output logic                                stat_table_id,
  output logic [15:0]                         capability_lst,
  output logic [3:0]                          capability_type,
  output logic                                enable,
  input  logic [N_TABLES-1:0][ADDR_W-1:0]     addr_limit,
  input  logic [N_DATA_BITS-1:0]              wr_dat,
  output logic [N_DATA_BITS-1:0]              rd_dat,
  indirect_access_cntrl_if.master             mem
);

  state_e                  state, nxt;
  ia_status_e              stat_r;
  logic                    init_r, sim_tmo_r, rst_r, rst_or_ini_r;
  logic                    cs_r, ce_r, we_r;
  logic [N_TIMER_BITS-1:0] timer_r;
  logic [ADDR_W-1:0]       rst_addr_r, maxaddr;
  logic                    cmnd_valid, cmnd_issued, unsupported_op, badaddr;
  logic                    igrant, timeout, tbl;
  logic                    op_read, op_write, op_enable, op_disable, op_reset;
  logic                    op_init, op_set_start, op_compare, op_sim_tmo, op_ack;

  // Only one table exists, so the table id never selects beyond entry 0.
  assign tbl = (N_TABLES > 1) ? cmnd_table_id : 1'b0;

  always_comb begin
    cmnd_valid     = wr_stb && (reg_addr == CMND_ADDRESS);
    op_read        = cmnd_valid && (cmnd_op == OP_READ);
    op_write       = cmnd_valid && (cmnd_op == OP_WRITE);
    op_enable      = cmnd_valid && (cmnd_op == OP_ENABLE);
    op_disable     = cmnd_valid && (cmnd_op == OP_DISABLE);
    op_reset       = cmnd_valid && (cmnd_op == OP_RESET);
    op_init        = cmnd_valid && ((cmnd_op == OP_INIT) || (cmnd_op == OP_INIT_INC));
    op_set_start   = cmnd_valid && (cmnd_op == OP_SET_INIT_START);
    op_compare     = cmnd_valid && (cmnd_op == OP_COMPARE);
    op_sim_tmo     = cmnd_valid && (cmnd_op == OP_SIM_TMO);
    op_ack         = cmnd_valid && (cmnd_op == OP_ACK_ERROR);
    unsupported_op = cmnd_valid && (cmnd_op >= 4'd10) && (cmnd_op <= 4'd13);
    cmnd_issued    = cmnd_valid && (cmnd_op != OP_NOP) && (cmnd_op != OP_SIM_TMO);
    maxaddr        = init_r ? '0 : addr_limit[tbl];
    badaddr        = cmnd_issued && (cmnd_addr > maxaddr);
    // A simulated timeout masks the grant so the busy state times out.
    igrant         = mem.grant && !sim_tmo_r;
    timeout        = &timer_r;

    nxt = state;
    case (state)
      S_POWERDOWN:    if (op_enable) nxt = S_READY;
      S_READY: begin
        if (op_write)            nxt = S_DO_WRITE;
        else if (op_read)        nxt = S_DO_READ;
        else if (op_compare)     nxt = S_DO_COMPARE;
        else if (op_reset)       nxt = S_DO_RESET;
        else if (op_init)        nxt = S_DO_INIT;
        else if (op_disable)     nxt = S_POWERDOWN;
        else if (unsupported_op) nxt = S_ERROR;
      end
      S_DO_WRITE:     if (igrant) nxt = S_READY;
      S_DO_READ:      if (igrant) nxt = S_READ_DONE;
      S_READ_DONE:    nxt = S_READY;
      S_DO_COMPARE:   if (igrant) nxt = S_COMPARE_WAIT;
      S_COMPARE_WAIT: nxt = S_COMPARE_DONE;
      S_COMPARE_DONE: nxt = S_READY;
      S_DO_RESET:     if (igrant && (rst_addr_r == maxaddr)) nxt = S_READY;
      S_DO_INIT:      if (igrant && (rst_addr_r == cmnd_addr)) nxt = S_READY;
      S_ERROR:        if (op_ack) nxt = init_r ? S_POWERDOWN : S_READY;
      default:        nxt = S_POWERDOWN;
    endcase

    // A timeout or a new command while a sequence is running is an error.
    if ((timeout || cmnd_issued) &&
        !(state inside {S_POWERDOWN, S_READY, S_ERROR}))
      nxt = S_ERROR;
    if (badaddr)
      nxt = S_ERROR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_POWERDOWN;
      stat_r       <= ST_PDN;
      init_r       <= 1'b1;
      rd_dat       <= '0;
      cs_r         <= 1'b0;
      ce_r         <= 1'b0;
      we_r         <= 1'b0;
      timer_r      <= '0;
      rst_addr_r   <= '0;
      sim_tmo_r    <= 1'b0;
      rst_r        <= 1'b0;
      rst_or_ini_r <= 1'b0;
    end else begin
      state        <= nxt;
      cs_r         <= 1'b0;
      ce_r         <= 1'b0;
      we_r         <= 1'b0;
      rst_r        <= 1'b0;
      rst_or_ini_r <= 1'b0;

      timer_r <= '0;
      if (nxt inside {S_DO_WRITE, S_DO_READ, S_DO_COMPARE, S_DO_RESET, S_DO_INIT})
        timer_r <= timer_r + 1'b1;
      if (igrant)
        timer_r <= '0;

      if (op_sim_tmo)
        sim_tmo_r <= 1'b1;
      else if (timeout)
        sim_tmo_r <= 1'b0;

      case (state)
        S_POWERDOWN:    rd_dat <= wr_dat;
        S_READ_DONE:    rd_dat <= mem.sw_rdat;
        S_COMPARE_DONE: rd_dat <= {87'b0, mem.sw_match, mem.sw_aindex};
        default: ;
      endcase

      if (state == S_POWERDOWN && nxt == S_READY)
        init_r <= 1'b0;

      if (state inside {S_DO_RESET, S_DO_INIT})
        rst_addr_r <= rst_addr_r + {{(ADDR_W-1){1'b0}}, igrant};
      if (op_set_start)
        rst_addr_r <= cmnd_addr;
      if (op_reset)
        rst_addr_r <= '0;

      case (nxt)
        S_POWERDOWN: begin
          stat_r <= ST_PDN;
          if (state != S_POWERDOWN) init_r <= 1'b1;
        end
        S_READY: stat_r <= ST_RDY;
        S_ERROR: begin
          // Status is latched on entry so the first cause is what software sees.
          if (state != S_ERROR) begin
            if (unsupported_op) stat_r <= ST_UOP;
            else if (badaddr)   stat_r <= ST_NXM;
            else if (timeout)   stat_r <= ST_TMO;
            else                stat_r <= ST_OVR;
          end
        end
        S_DO_WRITE: begin
          stat_r <= ST_BSY;
          cs_r   <= 1'b1;
          we_r   <= 1'b1;
        end
        S_DO_READ: begin
          stat_r <= ST_BSY;
          cs_r   <= 1'b1;
        end
        S_DO_COMPARE: begin
          stat_r <= ST_BSY;
          cs_r   <= 1'b1;
          ce_r   <= 1'b1;
        end
        S_DO_INIT: begin
          stat_r       <= ST_BSY;
          cs_r         <= 1'b1;
          we_r         <= 1'b1;
          rst_or_ini_r <= 1'b1;
        end
        S_DO_RESET: begin
          stat_r       <= ST_BSY;
          cs_r         <= 1'b1;
          we_r         <= 1'b1;
          rst_or_ini_r <= 1'b1;
          rst_r        <= 1'b1;
        end
        default: stat_r <= ST_BSY;
      endcase
    end
  end

  assign stat_code       = stat_r;
  assign stat_datawords  = N_DATAWORDS;
  assign stat_addr       = maxaddr;
  assign stat_table_id   = 1'b0;
  assign capability_lst  = CAPABILITIES;
  assign capability_type = MEM_TYPE;
  assign enable          = !init_r;

  assign mem.sw_cs   = cs_r;
  assign mem.sw_ce   = ce_r;
  assign mem.sw_we   = we_r;
  assign mem.sw_add  = rst_or_ini_r ? rst_addr_r : cmnd_addr;
  assign mem.sw_wdat = rst_r ? '0 : wr_dat;
  assign mem.yield   = timer_r[N_TIMER_BITS-1];
  assign mem.reset   = rst_or_ini_r;

endmodule

// File: tb/tb_indirect_access_cntrl.sv
// Directed self-checking bench for indirect_access_cntrl.
module tb_indirect_access_cntrl;
  import indirect_access_cntrl_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst_n;
  logic                            wr_stb;
  logic [N_REG_ADDR_BITS-1:0]      reg_addr;
  logic [3:0]                      cmnd_op;
  logic [ADDR_W-1:0]               cmnd_addr;
  logic                            cmnd_table_id;
  logic [2:0]                      stat_code;
  logic [4:0]                      stat_datawords;
  logic [ADDR_W-1:0]               stat_addr;
  logic                            stat_table_id;
  logic [15:0]                     capability_lst;
  logic [3:0]                      capability_type;
  logic                            enable;
  logic [N_TABLES-1:0][ADDR_W-1:0] addr_limit;
  logic [N_DATA_BITS-1:0]          wr_dat;
  logic [N_DATA_BITS-1:0]          rd_dat;

  int checks = 0;
  int errors = 0;
  int n;
  logic yield_seen;

  indirect_access_cntrl_if mem_if ();

  indirect_access_cntrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_stb          (wr_stb),
    .reg_addr        (reg_addr),
    .cmnd_op         (cmnd_op),
    .cmnd_addr       (cmnd_addr),
    .cmnd_table_id   (cmnd_table_id),
    .stat_code       (stat_code),
    .stat_datawords  (stat_datawords),
    .stat_addr       (stat_addr),
    .stat_table_id   (stat_table_id),
    .capability_lst  (capability_lst),
    .capability_type (capability_type),
    .enable          (enable),
    .addr_limit      (addr_limit),
    .wr_dat          (wr_dat),
    .rd_dat          (rd_dat),
    .mem             (mem_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [ADDR_W-1:0] addr);
    wr_stb    = 1'b1;
    reg_addr  = CMND_ADDRESS;
    cmnd_op   = op;
    cmnd_addr = addr;
    tick();
    wr_stb    = 1'b0;
  endtask

  initial begin
    rst_n             = 1'b0;
    wr_stb            = 1'b0;
    reg_addr          = '0;
    cmnd_op           = '0;
    cmnd_addr         = '0;
    cmnd_table_id     = 1'b0;
    addr_limit[0]     = 9'd511;
    wr_dat            = 96'h1234_5678_9ABC_DEF0_1122_3344;
    mem_if.grant      = 1'b1;
    mem_if.sw_rdat    = '0;
    mem_if.sw_match   = 1'b0;
    mem_if.sw_aindex  = '0;
    yield_seen        = 1'b0;
    tick();
    tick();

    check_val("rst_stat",   96'(stat_code), 96'd7);
    check_val("rst_enable", 96'(enable), 96'd0);
    check_val("rst_cs",     96'(mem_if.sw_cs), 96'd0);
    check_val("rst_rd_dat", rd_dat, 96'd0);

    rst_n = 1'b1;
    tick();
    tick();
    check_val("pdn_follow", rd_dat, 96'h1234_5678_9ABC_DEF0_1122_3344);
    check_val("pdn_maxaddr", 96'(stat_addr), 96'd0);
    check_val("dwords",     96'(stat_datawords), 96'd2);
    check_val("cap_lst",    96'(capability_lst), 96'hC17F);
    check_val("cap_type",   96'(capability_type), 96'd0);
    check_val("table_id",   96'(stat_table_id), 96'd0);

    // Command written to the wrong register address must be ignored.
    wr_stb   = 1'b1;
    reg_addr = STAT_ADDRESS;
    cmnd_op  = OP_ENABLE;
    tick();
    wr_stb   = 1'b0;
    check_val("wrong_addr", 96'(stat_code), 96'd7);

    issue(OP_ENABLE, 9'd0);
    check_val("en_stat",   96'(stat_code), 96'd0);
    check_val("en_enable", 96'(enable), 96'd1);
    check_val("en_maxaddr", 96'(stat_addr), 96'd511);

    // WRITE
    issue(OP_WRITE, 9'd5);
    check_val("wr_cs",   96'(mem_if.sw_cs), 96'd1);
    check_val("wr_we",   96'(mem_if.sw_we), 96'd1);
    check_val("wr_add",  96'(mem_if.sw_add), 96'd5);
    check_val("wr_wdat", mem_if.sw_wdat, 96'h1234_5678_9ABC_DEF0_1122_3344);
    check_val("wr_bsy",  96'(stat_code), 96'd1);
    tick();
    check_val("wr_cs_off", 96'(mem_if.sw_cs), 96'd0);
    check_val("wr_rdy",    96'(stat_code), 96'd0);

    // READ
    mem_if.sw_rdat = 96'hABC;
    issue(OP_READ, 9'd3);
    check_val("rd_cs", 96'(mem_if.sw_cs), 96'd1);
    check_val("rd_we", 96'(mem_if.sw_we), 96'd0);
    tick();
    check_val("rd_done_bsy", 96'(stat_code), 96'd1);
    tick();
    check_val("rd_dat", rd_dat, 96'hABC);
    check_val("rd_rdy", 96'(stat_code), 96'd0);

    // COMPARE
    mem_if.sw_match  = 1'b1;
    mem_if.sw_aindex = 8'h5A;
    issue(OP_COMPARE, 9'd2);
    check_val("cmp_ce", 96'(mem_if.sw_ce), 96'd1);
    tick();
    tick();
    tick();
    check_val("cmp_dat", rd_dat, 96'h15A);
    check_val("cmp_rdy", 96'(stat_code), 96'd0);

    // Out-of-range address
    addr_limit[0] = 9'd10;
    issue(OP_READ, 9'd11);
    check_val("nxm", 96'(stat_code), 96'd4);
    issue(OP_ACK_ERROR, 9'd0);
    check_val("nxm_ack", 96'(stat_code), 96'd0);
    issue(OP_READ, 9'd10);
    check_val("limit_ok", 96'(stat_code), 96'd1);
    tick();
    tick();

    // Simulated timeout
    issue(OP_SIM_TMO, 9'd0);
    check_val("simtmo_rdy", 96'(stat_code), 96'd0);
    issue(OP_WRITE, 9'd1);
    n = 0;
    while (stat_code == 3'd1 && n < 200) begin
      n++;
      if (mem_if.yield) yield_seen = 1'b1;
      tick();
    end
    check_val("tmo_cycles", 96'(n), 96'd63);
    check_val("tmo_stat",   96'(stat_code), 96'd2);
    check_val("tmo_yield",  96'(yield_seen), 96'd1);
    issue(OP_ACK_ERROR, 9'd0);
    check_val("tmo_ack", 96'(stat_code), 96'd0);

    // RESET sweep
    addr_limit[0] = 9'd3;
    issue(OP_RESET, 9'd0);
    for (int i = 0; i < 4; i++) begin
      check_val("rst_sw_cs",   96'(mem_if.sw_cs & mem_if.sw_we), 96'd1);
      check_val("rst_sw_add",  96'(mem_if.sw_add), 96'(i));
      check_val("rst_sw_wdat", mem_if.sw_wdat, 96'd0);
      check_val("rst_reset",   96'(mem_if.reset), 96'd1);
      tick();
    end
    check_val("rst_end_cs",  96'(mem_if.sw_cs), 96'd0);
    check_val("rst_end_rdy", 96'(stat_code), 96'd0);
    check_val("rst_end_rst", 96'(mem_if.reset), 96'd0);

    // INIT from a set start address
    addr_limit[0] = 9'd10;
    issue(OP_SET_INIT_START, 9'd2);
    issue(OP_INIT, 9'd4);
    for (int i = 2; i < 5; i++) begin
      check_val("ini_sw_add",  96'(mem_if.sw_add), 96'(i));
      check_val("ini_sw_wdat", mem_if.sw_wdat, 96'h1234_5678_9ABC_DEF0_1122_3344);
      tick();
    end
    check_val("ini_end_rdy", 96'(stat_code), 96'd0);

    // Unsupported opcode
    issue(4'd10, 9'd0);
    check_val("uop", 96'(stat_code), 96'd5);
    issue(OP_ACK_ERROR, 9'd0);
    check_val("uop_ack", 96'(stat_code), 96'd0);

    // Back to powerdown
    issue(OP_DISABLE, 9'd0);
    check_val("dis_stat",   96'(stat_code), 96'd7);
    check_val("dis_enable", 96'(enable), 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
